// File: rtl/id_pkg.sv
// Shared decode constants and types for the ID stage and its register file.
package id_pkg;

    localparam int unsigned NREG = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_BRANCH = 3'd1,
        BR_JUMP   = 3'd2
    } br_ctr_e;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_SQUASH = 1'b1
    } id_state_e;

    // ID/EX pipeline register payload
    typedef struct packed {
        logic          valid;
        alu_op_e       alu_op;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [AW-1:0] rd;
        logic          reg_write;
        logic          illegal;
    } de_payload_t;

    function automatic logic [DW-1:0] sext16(input logic [15:0] imm);
        return {{(DW-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two read ports, one write port, write-through bypass, r0 reads zero.
module reg_file
    import id_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);

    logic [DW-1:0] regs [0:NREG-1];
    logic          wr_en;

    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // A same-cycle write wins over the stored value
    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (wr_en && (wa == ra1)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (wr_en && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decodes IR, reads operands, resolves beq/bne/j and squashes the wrong-path slot.
module instruction_decode
    import id_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] PC,
    input  logic [DW-1:0] IR,
    input  logic [2:0]    FD_BranchCtr,
    input  logic          WB_RegWrite,
    input  logic [AW-1:0] WB_Rd,
    input  logic [DW-1:0] WB_Data,
    output logic [2:0]    BranchCtr,
    output logic [DW-1:0] BranchAddr,
    output logic          DE_Valid,
    output logic [2:0]    DE_AluOp,
    output logic [DW-1:0] DE_RsData,
    output logic [DW-1:0] DE_RtData,
    output logic [AW-1:0] DE_Rd,
    output logic          DE_RegWrite,
    output logic          DE_Illegal
);

    id_state_e     state_q, state_nxt;
    br_ctr_e       br_ctr_q, br_ctr_nxt;
    logic [DW-1:0] br_addr_q, br_addr_nxt;
    de_payload_t   de_q, de_nxt;

    logic [5:0]    opcode, funct;
    logic [AW-1:0] rs_idx, rt_idx, rd_idx;
    logic [DW-1:0] rs_val, rt_val, imm_ext, br_target, jump_target;
    logic [4:0]    unused_shamt;

    assign opcode       = IR[31:26];
    assign rs_idx       = IR[25:21];
    assign rt_idx       = IR[20:16];
    assign rd_idx       = IR[15:11];
    assign unused_shamt = IR[10:6];
    assign funct        = IR[5:0];
    assign imm_ext      = sext16(IR[15:0]);
    assign br_target    = PC + (imm_ext << 2);
    assign jump_target  = {PC[31:28], IR[25:0], 2'b00};

    reg_file u_reg_file (
        .clk (clk),
        .rst (rst),
        .ra1 (rs_idx),
        .ra2 (rt_idx),
        .rd1 (rs_val),
        .rd2 (rt_val),
        .we  (WB_RegWrite),
        .wa  (WB_Rd),
        .wd  (WB_Data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_NORMAL;
            br_ctr_q  <= BR_NONE;
            br_addr_q <= '0;
            de_q      <= '0;
        end else begin
            state_q   <= state_nxt;
            br_ctr_q  <= br_ctr_nxt;
            br_addr_q <= br_addr_nxt;
            de_q      <= de_nxt;
        end
    end

    // Decode, redirect resolution and squash control
    always_comb begin
        state_nxt      = state_q;
        br_ctr_nxt     = BR_NONE;
        br_addr_nxt    = br_addr_q;
        de_nxt         = '0;
        de_nxt.valid   = 1'b1;
        de_nxt.alu_op  = ALU_ADD;
        de_nxt.rs_data = rs_val;
        de_nxt.rt_data = rt_val;

        if (IR != '0) begin
            case (opcode)
                OP_RTYPE: begin
                    de_nxt.rd        = rd_idx;
                    de_nxt.reg_write = 1'b1;
                    case (funct)
                        FN_ADD:  de_nxt.alu_op = ALU_ADD;
                        FN_SUB:  de_nxt.alu_op = ALU_SUB;
                        FN_AND:  de_nxt.alu_op = ALU_AND;
                        FN_OR:   de_nxt.alu_op = ALU_OR;
                        FN_SLT:  de_nxt.alu_op = ALU_SLT;
                        default: begin
                            de_nxt.rd        = '0;
                            de_nxt.reg_write = 1'b0;
                            de_nxt.illegal   = 1'b1;
                        end
                    endcase
                end
                OP_ADDI: begin
                    de_nxt.rt_data   = imm_ext;
                    de_nxt.rd        = rt_idx;
                    de_nxt.reg_write = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    if ((rs_val == rt_val) == (opcode == OP_BEQ)) begin
                        br_ctr_nxt  = BR_BRANCH;
                        br_addr_nxt = br_target;
                    end
                end
                OP_J: begin
                    br_ctr_nxt  = BR_JUMP;
                    br_addr_nxt = jump_target;
                end
                default: de_nxt.illegal = 1'b1;
            endcase
        end

        // The slot after a redirect is the sequential wrong-path word
        if (state_q == ST_SQUASH) begin
            de_nxt.valid     = 1'b0;
            de_nxt.reg_write = 1'b0;
            de_nxt.illegal   = 1'b0;
            br_ctr_nxt       = BR_NONE;
            br_addr_nxt      = br_addr_q;
            state_nxt        = ST_NORMAL;
        end else if (br_ctr_nxt != BR_NONE) begin
            state_nxt = ST_SQUASH;
        end
    end

    assign BranchCtr   = br_ctr_q;
    assign BranchAddr  = br_addr_q;
    assign DE_Valid    = de_q.valid;
    assign DE_AluOp    = de_q.alu_op;
    assign DE_RsData   = de_q.rs_data;
    assign DE_RtData   = de_q.rt_data;
    assign DE_Rd       = de_q.rd;
    assign DE_RegWrite = de_q.reg_write;
    assign DE_Illegal  = de_q.illegal;

    // Fetch must echo the redirect it saw one cycle earlier
    logic [2:0] prev_branch_ctr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_branch_ctr <= '0;
        end else begin
            prev_branch_ctr <= BranchCtr;
        end
    end

    fd_echo_a: assert property (@(posedge clk) disable iff (!rst) FD_BranchCtr == prev_branch_ctr);

endmodule

// File: tb/tb_instruction_decode.sv
// Directed vector table, reset corner sequence and randomized run against a decode model.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC, IR;
    logic [2:0]  FD_BranchCtr;
    logic        WB_RegWrite;
    logic [4:0]  WB_Rd;
    logic [31:0] WB_Data;
    logic [2:0]  BranchCtr;
    logic [31:0] BranchAddr;
    logic        DE_Valid;
    logic [2:0]  DE_AluOp;
    logic [31:0] DE_RsData, DE_RtData;
    logic [4:0]  DE_Rd;
    logic        DE_RegWrite, DE_Illegal;

    int checks = 0;
    int errors = 0;

    instruction_decode dut (
        .clk(clk), .rst(rst), .PC(PC), .IR(IR), .FD_BranchCtr(FD_BranchCtr),
        .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
        .BranchCtr(BranchCtr), .BranchAddr(BranchAddr), .DE_Valid(DE_Valid),
        .DE_AluOp(DE_AluOp), .DE_RsData(DE_RsData), .DE_RtData(DE_RtData),
        .DE_Rd(DE_Rd), .DE_RegWrite(DE_RegWrite), .DE_Illegal(DE_Illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [2:0]  bc;
        logic [31:0] ba;
        logic        valid;
        logic        rw;
        logic        ill;
        logic        chkd;
        logic [2:0]  alu;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] m_regs [32];
    logic        m_sq;
    logic [31:0] m_ba;

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] ir, input logic we,
                                input logic [4:0] wrd, input logic [31:0] wdata,
                                input logic [2:0] bc, input logic [31:0] ba, input logic valid,
                                input logic rw, input logic ill, input logic chkd,
                                input logic [2:0] alu, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [4:0] rd);
        vec_t v;
        v.pc = pc; v.ir = ir; v.we = we; v.wrd = wrd; v.wdata = wdata;
        v.bc = bc; v.ba = ba; v.valid = valid; v.rw = rw; v.ill = ill;
        v.chkd = chkd; v.alu = alu; v.rs = rs; v.rt = rt; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ir, input logic we,
                         input logic [4:0] wrd, input logic [31:0] wdata);
        PC = pc; IR = ir; WB_RegWrite = we; WB_Rd = wrd; WB_Data = wdata;
    endtask

    // One clock; fetch's echo of the redirect it just consumed follows the edge
    task automatic step();
        logic [2:0] bc_before;
        bc_before = BranchCtr;
        @(posedge clk);
        #1;
        FD_BranchCtr = bc_before;
    endtask

    task automatic chk_ctl(input string tag, input logic [2:0] bc, input logic [31:0] ba,
                           input logic valid, input logic rw, input logic ill);
        chk({tag, " BranchCtr"}, 32'(BranchCtr), 32'(bc));
        chk({tag, " BranchAddr"}, BranchAddr, ba);
        chk({tag, " DE_Valid"}, 32'(DE_Valid), 32'(valid));
        chk({tag, " DE_RegWrite"}, 32'(DE_RegWrite), 32'(rw));
        chk({tag, " DE_Illegal"}, 32'(DE_Illegal), 32'(ill));
    endtask

    task automatic chk_data(input string tag, input logic [2:0] alu, input logic [31:0] rs,
                            input logic [31:0] rt, input logic [4:0] rd);
        chk({tag, " DE_AluOp"}, 32'(DE_AluOp), 32'(alu));
        chk({tag, " DE_RsData"}, DE_RsData, rs);
        chk({tag, " DE_RtData"}, DE_RtData, rt);
        chk({tag, " DE_Rd"}, 32'(DE_Rd), 32'(rd));
    endtask

    task automatic chk_all_zero(input string tag);
        chk_ctl(tag, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_data(tag, 3'd0, 32'h0, 32'h0, 5'd0);
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wrd, input logic [31:0] wdata);
        if (idx == 5'd0) return 32'h0;
        if (we && wrd == idx) return wdata;
        return m_regs[idx];
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] legal_fn [5];
        logic [5:0] bad_op [4];
        legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        bad_op   = '{6'h3F, 6'h23, 6'h2B, 6'h01};

        rst = 1'b1;
        FD_BranchCtr = 3'd0;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2 rst = 1'b0;
        #10;
        chk_all_zero("reset");
        #10 rst = 1'b1;

        //     pc            ir                                    we    wrd    wdata          bc    ba            v     rw    ill   chkd  alu   rs            rt            rd
        vecs.push_back(mk(32'h0,        enc_r(6'h20,5'd3,5'd3,5'd1,5'd0), 1'b1, 5'd3, 32'h12,   3'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h12,       32'h12,       5'd1));
        vecs.push_back(mk(32'h0,        32'h0,                            1'b1, 5'd1, 32'h7,    3'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        5'd0));
        vecs.push_back(mk(32'h0,        enc_r(6'h25,5'd3,5'd0,5'd4,5'd0), 1'b1, 5'd2, 32'h7,    3'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 32'h12,       32'h0,        5'd4));
        vecs.push_back(mk(32'h10,       enc_i(6'h04,5'd1,5'd2,16'hFFFE),  1'b0, 5'd0, 32'h0,    3'd1, 32'h8,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        5'd0));
        vecs.push_back(mk(32'h14,       enc_j(26'h40),                    1'b0, 5'd0, 32'h0,    3'd0, 32'h8,        1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        5'd0));
        vecs.push_back(mk(32'h18,       enc_i(6'h08,5'd0,5'd2,16'h0002),  1'b1, 5'd1, 32'h1,    3'd0, 32'h8,        1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0,        32'h2,        5'd2));
        vecs.push_back(mk(32'h20,       enc_i(6'h04,5'd1,5'd2,16'h0005),  1'b1, 5'd2, 32'h2,    3'd0, 32'h8,        1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        5'd0));
        vecs.push_back(mk(32'h24,       enc_i(6'h08,5'd1,5'd5,16'hFFFF),  1'b0, 5'd0, 32'h0,    3'd0, 32'h8,        1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h1,        32'hFFFFFFFF, 5'd5));
        vecs.push_back(mk(32'h30000008, enc_j(26'h40),                    1'b0, 5'd0, 32'h0,    3'd2, 32'h30000100, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        5'd0));
        vecs.push_back(mk(32'h3000000C, enc_r(6'h20,5'd1,5'd1,5'd6,5'd0), 1'b0, 5'd0, 32'h0,    3'd0, 32'h30000100, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        5'd0));
        vecs.push_back(mk(32'h40,       32'hFC000000,                     1'b0, 5'd0, 32'h0,    3'd0, 32'h30000100, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0,        32'h0,        5'd0));
        vecs.push_back(mk(32'h44,       32'h0,                            1'b0, 5'd0, 32'h0,    3'd0, 32'h30000100, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        5'd0));
        vecs.push_back(mk(32'h48,       enc_r(6'h20,5'd0,5'd0,5'd7,5'd0), 1'b1, 5'd0, 32'hDEAD, 3'd0, 32'h30000100, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0,        32'h0,        5'd7));
        vecs.push_back(mk(32'h4C,       enc_r(6'h22,5'd0,5'd3,5'd8,5'd0), 1'b0, 5'd0, 32'h0,    3'd0, 32'h30000100, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 32'h0,        32'h12,       5'd8));
        vecs.push_back(mk(32'h4,        enc_i(6'h05,5'd1,5'd2,16'hFFFE),  1'b0, 5'd0, 32'h0,    3'd1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        5'd0));
        vecs.push_back(mk(32'h8,        32'hFC000000,                     1'b0, 5'd0, 32'h0,    3'd0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        5'd0));
        vecs.push_back(mk(32'h60,       enc_r(6'h2A,5'd1,5'd2,5'd9,5'd0), 1'b0, 5'd0, 32'h0,    3'd0, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 32'h1,        32'h2,        5'd9));
        vecs.push_back(mk(32'h64,       enc_r(6'h24,5'd3,5'd2,5'd10,5'd0),1'b0, 5'd0, 32'h0,    3'd0, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 32'h12,       32'h2,        5'd10));

        foreach (vecs[i]) begin
            drive(vecs[i].pc, vecs[i].ir, vecs[i].we, vecs[i].wrd, vecs[i].wdata);
            step();
            chk_ctl($sformatf("vec%0d", i), vecs[i].bc, vecs[i].ba, vecs[i].valid,
                    vecs[i].rw, vecs[i].ill);
            if (vecs[i].chkd)
                chk_data($sformatf("vec%0d", i), vecs[i].alu, vecs[i].rs, vecs[i].rt, vecs[i].rd);
        end

        // Reset while in the squash slot, with r5 holding a nonzero value
        drive(32'h40, enc_j(26'h10), 1'b1, 5'd5, 32'h55);
        step();
        chk("presquash BranchCtr", 32'(BranchCtr), 32'd2);
        drive(32'h44, 32'h0, 1'b0, 5'd0, 32'h0);
        #2 rst = 1'b0;
        FD_BranchCtr = 3'd0;
        #1;
        chk_all_zero("midsquash_reset");
        @(negedge clk);
        rst = 1'b1;
        drive(32'h0, enc_r(6'h20, 5'd5, 5'd5, 5'd1, 5'd0), 1'b0, 5'd0, 32'h0);
        step();
        chk_ctl("post_reset", 3'd0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk_data("post_reset", 3'd0, 32'h0, 32'h0, 5'd1);

        // Randomized run against the decode model, starting from cleared state
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_sq = 1'b0;
        m_ba = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic        we;
            logic [4:0]  wrd, rs, rt, rd, sh;
            logic [31:0] wdata, ir, pc, rsv, rtv;
            logic [2:0]  e_bc, e_alu;
            logic        e_valid, e_rw, e_ill, e_chkd, taken;
            logic [31:0] e_rs, e_rt;
            logic [4:0]  e_rd;
            int          kind;
            logic [5:0]  op;

            we    = 1'($urandom_range(0, 1));
            wrd   = 5'($urandom_range(0, 7));
            wdata = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            rs    = 5'($urandom_range(0, 7));
            rt    = 5'($urandom_range(0, 7));
            rd    = 5'($urandom_range(0, 31));
            sh    = 5'($urandom_range(0, 31));
            pc    = 32'($urandom) & 32'hFFFF_FFFC;
            kind  = $urandom_range(0, 9);
            case (kind)
                0, 1, 2: ir = enc_r(legal_fn[$urandom_range(0, 4)], rs, rt, rd, sh);
                3:       ir = enc_i(6'h08, rs, rt, 16'($urandom));
                4:       ir = enc_i(6'h04, rs, rt, 16'($urandom));
                5:       ir = enc_i(6'h05, rs, rt, 16'($urandom));
                6:       ir = enc_j(26'($urandom));
                7:       ir = 32'h0;
                8:       ir = {bad_op[$urandom_range(0, 3)], 26'($urandom)};
                default: ir = enc_r(6'h08, rs, rt, rd, sh);
            endcase

            rsv = m_read(ir[25:21], we, wrd, wdata);
            rtv = m_read(ir[20:16], we, wrd, wdata);
            op  = ir[31:26];
            e_bc = 3'd0; e_valid = 1'b1; e_rw = 1'b0; e_ill = 1'b0; e_chkd = 1'b0;
            e_alu = 3'd0; e_rs = rsv; e_rt = rtv; e_rd = 5'd0;
            if (m_sq) begin
                e_valid = 1'b0;
                m_sq    = 1'b0;
            end else if (ir == 32'h0) begin
                e_valid = 1'b1;
            end else if (op == 6'h00 && (ir[5:0] == 6'h20 || ir[5:0] == 6'h22 ||
                         ir[5:0] == 6'h24 || ir[5:0] == 6'h25 || ir[5:0] == 6'h2A)) begin
                e_rw = 1'b1; e_chkd = 1'b1; e_rd = ir[15:11];
                case (ir[5:0])
                    6'h20:   e_alu = 3'd0;
                    6'h22:   e_alu = 3'd1;
                    6'h24:   e_alu = 3'd2;
                    6'h25:   e_alu = 3'd3;
                    default: e_alu = 3'd4;
                endcase
            end else if (op == 6'h08) begin
                e_rw = 1'b1; e_chkd = 1'b1; e_rd = ir[20:16];
                e_rt = 32'(int'($signed(ir[15:0])));
            end else if (op == 6'h04 || op == 6'h05) begin
                taken = (rsv == rtv) ? (op == 6'h04) : (op == 6'h05);
                if (taken) begin
                    e_bc = 3'd1;
                    m_ba = pc + 32'(int'($signed(ir[15:0])) * 4);
                    m_sq = 1'b1;
                end
            end else if (op == 6'h02) begin
                e_bc = 3'd2;
                m_ba = {pc[31:28], ir[25:0], 2'b00};
                m_sq = 1'b1;
            end else begin
                e_ill = 1'b1;
            end

            drive(pc, ir, we, wrd, wdata);
            step();
            chk_ctl($sformatf("rnd%0d", n), e_bc, m_ba, e_valid, e_rw, e_ill);
            if (e_chkd)
                chk_data($sformatf("rnd%0d", n), e_alu, e_rs, e_rt, e_rd);
            if (we && wrd != 5'd0) m_regs[wrd] = wdata;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- ID stage: the consumer of the fetch stage's PC/IR output and the producer of its BranchCtr/BranchAddr redirect inputs.
- Decodes the instruction, reads a 32x32 register file (WB write port, write-through bypass) and resolves beq/bne/j in-stage.
- Registers a one-cycle redirect pulse back to fetch.
- Registers decoded operands into the ID/EX pipeline register.

Parameters:
- NREG, 32, register count (5-bit indices).
- DW, 32, datapath width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- PC  input  32  from fetch: address of IR + 4.
- IR  input  32  instruction from fetch.
- FD_BranchCtr  input  3  fetch echo of last redirect; used only by the assertion check.
- WB_RegWrite  input  1  writeback enable.
- WB_Rd  input  5  writeback index.
- WB_Data  input  32  writeback data.
- BranchCtr  output  3  registered: 0 none, 1 branch taken, 2 jump.
- BranchAddr  output  32  registered redirect target.
- DE_Valid  output  1  ID/EX slot holds a real instruction.
- DE_AluOp  output  3  0 add, 1 sub, 2 and, 3 or, 4 slt.
- DE_RsData  output  32  operand A.
- DE_RtData  output  32  operand B (register or sign-extended immediate).
- DE_Rd  output  5  destination index.
- DE_RegWrite  output  1  EX result must be written back.
- DE_Illegal  output  1  one-cycle flag for an unknown opcode/funct.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0.
  - All 32 registers 0.
  - State = NORMAL.
- Decode is combinational from IR. All outputs are registered with 1-cycle latency.

Decoded instructions (MIPS encoding):
- opcode 0, funct 0x20/0x22/0x24/0x25/0x2A: add/sub/and/or/slt. Rd = IR[15:11], RegWrite = 1.
- IR == 0: nop. DE_Valid = 1, RegWrite = 0.
- addi (0x08): AluOp add, RtData = sext(IR[15:0]), Rd = IR[20:16].
- beq (0x04) / bne (0x05):
  - Compare rs vs rt after bypass.
  - If taken: BranchCtr <= 1, BranchAddr <= PC + (sext(IR[15:0]) << 2), mod 2^32.
  - Not taken: BranchCtr <= 0.
  - DE_RegWrite = 0 in both cases.
- j (0x02): BranchCtr <= 2, BranchAddr <= {PC[31:28], IR[25:0], 2'b00}.
- Any other encoding: treated as nop, DE_Illegal <= 1 for one cycle.

Register file:
- Write on the clk edge when WB_RegWrite and WB_Rd != 0. r0 always reads 0.
- Read bypass: if WB_RegWrite and WB_Rd == index != 0, the read returns WB_Data in the same cycle.
- No interlock against instructions still in EX/MEM. Software inserts 2 nops between a producer and a dependent branch.

State machine:
- NORMAL:
  - Decode normally.
  - On a taken branch or jump, issue the redirect and move to SQUASH.
- SQUASH:
  - The incoming IR is the sequential wrong-path word fetched at the redirect edge.
  - Drive DE_Valid <= 0, DE_RegWrite <= 0, BranchCtr <= 0, DE_Illegal <= 0.
  - A branch, jump or illegal word in this slot is ignored.
  - Return to NORMAL.
- BranchCtr is nonzero for exactly one cycle per redirect. Back-to-back redirects are impossible; the minimum spacing is 2 cycles.
- BranchAddr holds its last value when BranchCtr = 0.

Simultaneous events and boundaries:
- WB writing a register that the ID instruction reads in the same cycle: the bypass value is used.
- rst asserted mid-SQUASH: return to NORMAL, all outputs 0.
- BranchAddr wraps mod 2^32 (e.g. PC=0x4, offset -2 gives 0xFFFFFFFC).
- A write with WB_Rd = 0 is discarded.
- Assertion (sim only): FD_BranchCtr equals the previous cycle's BranchCtr.

Decomposition:
- Shared package (id_pkg):
  - Opcode/funct constants.
  - AluOp encodings.
  - BranchCtr encodings: BR_NONE=0, BR_BRANCH=1, BR_JUMP=2.
- Sub-module reg_file: 2 read ports, 1 write port, async active-low clear, write-through bypass, r0 hardwired to 0.

Test Plan:
- Reset: rst=0 mid-run, then release → every output 0; read of r5 returns 0; state NORMAL.
- Same-cycle bypass: WB writes r3=0x12 while IR=add r1,r3,r3 → next cycle DE_RsData=DE_RtData=0x12, DE_Rd=1, DE_RegWrite=1, DE_AluOp=0.
- Taken branch, then squash:
  - Setup: r1=r2=7, IR=beq r1,r2,-2, PC=0x10.
  - Next cycle: BranchCtr=1, BranchAddr=0x8, DE_Valid=1, DE_RegWrite=0.
  - Cycle after, with IR=jump word: DE_Valid=0, BranchCtr=0.
- Not-taken branch: r1=1, r2=2, IR=beq → BranchCtr=0, no squash; the next addi decodes with DE_Valid=1.
- Jump: IR=j 0x0000040, PC=0x30000008 → BranchCtr=2, BranchAddr=0x30000100; the following slot is squashed.
- Illegal word: IR=0xFC000000 → DE_Illegal=1 for 1 cycle, DE_RegWrite=0. Separately, a WB write to r0 → r0 still reads 0.
